// File: rtl/mask_seq_pkg.sv
// mask_seq_pkg -- shared types, constants and helpers for the mask sequence generator.
//   state_t      : sequencer states IDLE, LOAD, FILL, WAIT, DONE
//   MODE_*       : step-mode encodings for the 2-bit mode input (3 is reserved and holds)
//   win_valid    : true when win_lo..win_hi selects a legal sub-range of the word
//   window_mask  : bit mask of the active window (full word when the range is illegal)
//   lfsr_taps    : maximal-length Fibonacci tap mask for window lengths 2..MAX_CH
package mask_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, FILL, WAIT, DONE} state_t;

    localparam logic [1:0] MODE_HOLD   = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;

    // Widest word the tap table covers; N_CH must not exceed this.
    localparam int MAX_CH = 16;

    function automatic bit win_valid(input int lo, input int hi, input int n_ch);
        return (lo <= hi) && (hi < n_ch);
    endfunction

    function automatic logic [31:0] window_mask(input int lo, input int hi, input int n_ch);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (win_valid(lo, hi, n_ch) ? (i >= lo && i <= hi) : (i < n_ch))
                m[i] = 1'b1;
        end
        return m;
    endfunction

    // Bit k set means window stage k+1 feeds the XOR (stage 1 sits at win_lo).
    function automatic logic [31:0] lfsr_taps(input int len);
        case (len)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/mask_word_step.sv
// mask_word_step -- combinational next-word function for one mask word.
//   word      in  N_CH   current mask word
//   mode      in  2      HOLD / ROTATE / LFSR / reserved(HOLD)
//   win_lo    in  IDX_W  lowest window bit
//   win_hi    in  IDX_W  highest window bit
//   next_word out N_CH   word after one step; bits outside the window pass through
// Build option: MASK_SEQ_LFSR_EN enables the LFSR step for mode 2; without it
// mode 2 holds and no LFSR logic exists.
module mask_word_step
    import mask_seq_pkg::*;
#(
    parameter int N_CH  = 10,
    parameter int IDX_W = 4
) (
    input  logic [N_CH-1:0]  word,
    input  logic [1:0]       mode,
    input  logic [IDX_W-1:0] win_lo,
    input  logic [IDX_W-1:0] win_hi,
    output logic [N_CH-1:0]  next_word
);

    int              lo_eff;
    int              win_len;
    logic [N_CH-1:0] len_mask;
    logic [N_CH-1:0] win_mask;
    logic [N_CH-1:0] win;
    logic [N_CH-1:0] new_win;

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        lo_eff  = 0;
        win_len = N_CH;
        if (win_valid(int'(win_lo), int'(win_hi), N_CH)) begin
            lo_eff  = int'(win_lo);
            win_len = int'(win_hi) - int'(win_lo) + 1;
        end
        len_mask = N_CH'((32'h1 << win_len) - 32'h1);
        win_mask = len_mask << lo_eff;
        // Work on the window right-aligned at bit 0, then put it back.
        win      = (word >> lo_eff) & len_mask;
        new_win  = win;
        case (mode)
            MODE_ROTATE: new_win = ((win << 1) | (win >> (win_len - 1))) & len_mask;
`ifdef MASK_SEQ_LFSR_EN
            MODE_LFSR: begin
                if (win_len == 1)
                    new_win = ~win & len_mask;
                else if (win == '0)
                    new_win = N_CH'(1);   // escape the all-zero lock-up state
                else
                    new_win = ((win << 1) | N_CH'(^(win & N_CH'(lfsr_taps(win_len))))) & len_mask;
            end
`endif
            default:     new_win = win;
        endcase
        next_word = (word & ~win_mask) | ((new_win << lo_eff) & win_mask);
    end

endmodule

// File: rtl/mask_seq_gen.sv
// mask_seq_gen -- emits num_pat N_CH-bit mask words per exposure subframe into
// the mask FIFO, stepping a per-channel window and scheduling mask changes.
//   clk, rst        CLK_HS, synchronous active-high reset
//   enable          level; rising edge latches config and starts a sequence
//   mode            0 HOLD, 1 ROTATE, 2 LFSR (HOLD unless MASK_SEQ_LFSR_EN), 3 HOLD
//   pat_in          seed word;  win_lo/win_hi  active window
//   num_pat         words per subframe
//   mask_chng_subc  subframes per mask change (0 -> 1)
//   mask_chng_no    mask changes before done (0 -> forever)
//   subc_tick       subframe boundary pulse;  pat_ready  FIFO can accept
//   pat_valid/pat_data  FIFO write side;  done  sequence complete
//   overrun         sticky: a subframe tick was lost
// Build option: MASK_SEQ_LFSR_EN (see mask_word_step).
module mask_seq_gen
    import mask_seq_pkg::*;
#(
    parameter int N_CH  = 10,
    parameter int CNT_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [N_CH-1:0]  pat_in,
    input  logic [IDX_W-1:0] win_lo,
    input  logic [IDX_W-1:0] win_hi,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [CNT_W-1:0] mask_chng_subc,
    input  logic [CNT_W-1:0] mask_chng_no,
    input  logic             subc_tick,
    input  logic             pat_ready,
    output logic             pat_valid,
    output logic [N_CH-1:0]  pat_data,
    output logic             done,
    output logic             overrun
);

    state_t           state;
    logic             enable_q;
    logic [1:0]       cfg_mode;
    logic [N_CH-1:0]  cfg_seed;
    logic [IDX_W-1:0] cfg_win_lo, cfg_win_hi;
    logic [CNT_W-1:0] cfg_num_pat, cfg_subc, cfg_chng_no;
    logic [N_CH-1:0]  base, work;
    logic [CNT_W-1:0] wcnt, scnt, ccnt;
    logic             pend;

    logic [N_CH-1:0]  work_step, base_step, seed, refill;
    logic [CNT_W-1:0] eff_subc;
    logic             en_rise, tick, sub_more, last_chng, last_word;

    mask_word_step #(.N_CH(N_CH), .IDX_W(IDX_W)) u_step_work (
        .word(work), .mode(cfg_mode), .win_lo(cfg_win_lo), .win_hi(cfg_win_hi),
        .next_word(work_step)
    );

    mask_word_step #(.N_CH(N_CH), .IDX_W(IDX_W)) u_step_base (
        .word(base), .mode(cfg_mode), .win_lo(cfg_win_lo), .win_hi(cfg_win_hi),
        .next_word(base_step)
    );

`ifdef MASK_SEQ_LFSR_EN
    // An all-zero LFSR seed window would never advance; start it at 1 instead.
    logic [N_CH-1:0] seed_win;
    always_comb begin
        seed_win = N_CH'(window_mask(int'(cfg_win_lo), int'(cfg_win_hi), N_CH));
        seed     = cfg_seed;
        if (cfg_mode == MODE_LFSR && (cfg_seed & seed_win) == '0)
            seed = cfg_seed | (seed_win & (~seed_win + N_CH'(1)));
    end
`else
    assign seed = cfg_seed;
`endif

    assign en_rise   = enable & ~enable_q;
    assign tick      = subc_tick | pend;
    assign eff_subc  = (cfg_subc == '0) ? CNT_W'(1) : cfg_subc;
    assign sub_more  = (scnt + CNT_W'(1)) < eff_subc;
    assign last_chng = (cfg_chng_no != '0) && (ccnt + CNT_W'(1) == cfg_chng_no);
    assign last_word = wcnt == cfg_num_pat - CNT_W'(1);
    // Repeat the current mask, or advance it on a mask change.
    assign refill    = sub_more ? base : base_step;

    // NOTE: sequential state uses non-blocking assignments so every register
    // is updated from the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            enable_q    <= 1'b0;
            cfg_mode    <= MODE_HOLD;
            cfg_seed    <= '0;
            cfg_win_lo  <= '0;
            cfg_win_hi  <= '0;
            cfg_num_pat <= '0;
            cfg_subc    <= '0;
            cfg_chng_no <= '0;
            base        <= '0;
            work        <= '0;
            wcnt        <= '0;
            scnt        <= '0;
            ccnt        <= '0;
            pend        <= 1'b0;
            pat_valid   <= 1'b0;
            pat_data    <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            enable_q <= enable;
            if (!enable) begin
                state     <= IDLE;
                pat_valid <= 1'b0;
                done      <= 1'b0;
                pend      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en_rise) begin
                            cfg_mode    <= mode;
                            cfg_seed    <= pat_in;
                            cfg_win_lo  <= win_lo;
                            cfg_win_hi  <= win_hi;
                            cfg_num_pat <= num_pat;
                            cfg_subc    <= mask_chng_subc;
                            cfg_chng_no <= mask_chng_no;
                            overrun     <= 1'b0;
                            pend        <= 1'b0;
                            state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        base <= seed;
                        work <= seed;
                        wcnt <= '0;
                        scnt <= '0;
                        ccnt <= '0;
                        if (subc_tick) begin
                            overrun <= overrun | pend;
                            pend    <= 1'b1;
                        end
                        if (cfg_num_pat == '0) begin
                            state <= WAIT;
                        end else begin
                            state     <= FILL;
                            pat_valid <= 1'b1;
                            pat_data  <= seed;
                        end
                    end
                    FILL: begin
                        if (subc_tick) begin
                            overrun <= overrun | pend;
                            pend    <= 1'b1;
                        end
                        if (pat_ready) begin
                            work <= work_step;
                            if (last_word) begin
                                wcnt      <= '0;
                                pat_valid <= 1'b0;
                                state     <= WAIT;
                            end else begin
                                wcnt     <= wcnt + CNT_W'(1);
                                pat_data <= work_step;
                            end
                        end
                    end
                    WAIT: begin
                        if (tick) begin
                            // A fresh tick coinciding with a pending one stays queued.
                            pend <= subc_tick & pend;
                            work <= refill;
                            if (sub_more) begin
                                scnt <= scnt + CNT_W'(1);
                            end else begin
                                scnt <= '0;
                                ccnt <= (ccnt == '1) ? ccnt : ccnt + CNT_W'(1);
                                base <= base_step;
                            end
                            if (!sub_more && last_chng) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else if (cfg_num_pat != '0) begin
                                state     <= FILL;
                                pat_valid <= 1'b1;
                                pat_data  <= refill;
                                wcnt      <= '0;
                            end
                        end
                    end
                    DONE: begin
                        done      <= 1'b1;
                        pat_valid <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mask_seq_gen.sv
// tb_mask_seq_gen -- directed and randomized checks of mask_seq_gen against a
// word-list reference model built from the sequencing rules.
module tb_mask_seq_gen;

    localparam int N_CH  = 10;
    localparam int CNT_W = 16;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst, enable, subc_tick, pat_ready;
    logic [1:0]       mode;
    logic [N_CH-1:0]  pat_in;
    logic [IDX_W-1:0] win_lo, win_hi;
    logic [CNT_W-1:0] num_pat, mask_chng_subc, mask_chng_no;
    logic             pat_valid, done, overrun;
    logic [N_CH-1:0]  pat_data;

    int n_checks   = 0;
    int n_fail     = 0;
    int ready_mode = 0;
    bit mon_en     = 1'b0;

    logic [N_CH-1:0] recv_q[$];
    logic [N_CH-1:0] exp_q[$];
    logic            prev_hold = 1'b0;
    logic [N_CH-1:0] prev_data = '0;

    mask_seq_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .pat_in(pat_in),
        .win_lo(win_lo), .win_hi(win_hi), .num_pat(num_pat),
        .mask_chng_subc(mask_chng_subc), .mask_chng_no(mask_chng_no),
        .subc_tick(subc_tick), .pat_ready(pat_ready), .pat_valid(pat_valid),
        .pat_data(pat_data), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge: record accepted words and check hold-while-stalled.
    always @(negedge clk) begin
        if (mon_en && prev_hold) begin
            check("stall_valid", 32'(pat_valid), 32'd1);
            check("stall_data", 32'(pat_data), 32'(prev_data));
        end
        prev_hold <= mon_en && pat_valid && !pat_ready;
        prev_data <= pat_data;
        if (mon_en && pat_valid && pat_ready) recv_q.push_back(pat_data);
    end

    // Reference step: rotate a list of window bits; HOLD/reserved/disabled-LFSR return the word.
    function automatic logic [N_CH-1:0] ref_step(input logic [N_CH-1:0] w, input int md,
                                                 input int lo, input int hi);
        bit              bits[$];
        logic [N_CH-1:0] r;
        r = w;
        if (!(lo <= hi && hi < N_CH)) begin
            lo = 0;
            hi = N_CH - 1;
        end
        if (md != 1) return w;
        for (int i = lo; i <= hi; i++) bits.push_back(w[i]);
        bits.push_front(bits.pop_back());
        for (int i = lo; i <= hi; i++) r[i] = bits[i - lo];
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        subc_tick = 1'b0;
        case (ready_mode)
            0:       pat_ready = 1'b1;
            1:       pat_ready = ~pat_ready;
            default: pat_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse_tick();
        subc_tick = 1'b1;
        cycle();
    endtask

    // Drop enable, present a config, raise enable; returns after the LOAD edge.
    task automatic start_seq(input int md, input logic [N_CH-1:0] seed, input int lo, input int hi,
                             input int np, input int subc, input int nchg);
        mon_en = 1'b0;
        enable = 1'b0;
        cycle();
        cycle();
        mode           = 2'(md);
        pat_in         = seed;
        win_lo         = IDX_W'(lo);
        win_hi         = IDX_W'(hi);
        num_pat        = CNT_W'(np);
        mask_chng_subc = CNT_W'(subc);
        mask_chng_no   = CNT_W'(nchg);
        enable         = 1'b1;
        recv_q.delete();
        mon_en         = 1'b1;
        cycle();
    endtask

    task automatic wait_count(input string tag, input int target);
        int budget;
        budget = 400;
        while (recv_q.size() < target && budget > 0) begin
            cycle();
            budget--;
        end
        repeat (4) cycle();
        check(tag, 32'(recv_q.size()), 32'(target));
    endtask

    task automatic run_scenario(input string tag, input int md, input logic [N_CH-1:0] seed,
                                input int lo, input int hi, input int np, input int subc,
                                input int nchg);
        int              eff, n_sub;
        logic [N_CH-1:0] base, w;
        eff   = (subc == 0) ? 1 : subc;
        n_sub = nchg * eff;
        exp_q.delete();
        base = seed;
        for (int c = 0; c < nchg; c++) begin
            for (int s = 0; s < eff; s++) begin
                w = base;
                for (int k = 0; k < np; k++) begin
                    exp_q.push_back(w);
                    w = ref_step(w, md, lo, hi);
                end
            end
            base = ref_step(base, md, lo, hi);
        end
        start_seq(md, seed, lo, hi, np, subc, nchg);
        // Config changes after the start edge must have no effect.
        pat_in  = N_CH'($urandom);
        mode    = 2'($urandom_range(0, 3));
        win_lo  = IDX_W'($urandom);
        win_hi  = IDX_W'($urandom);
        num_pat = CNT_W'($urandom_range(1, 9));
        mask_chng_subc = CNT_W'($urandom_range(0, 4));
        mask_chng_no   = CNT_W'($urandom_range(0, 4));
        for (int s = 0; s < n_sub; s++) begin
            wait_count({tag, "_count"}, (s + 1) * np);
            check({tag, "_notdone"}, 32'(done), 32'd0);
            pulse_tick();
        end
        repeat (3) cycle();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid_low"}, 32'(pat_valid), 32'd0);
        repeat (5) cycle();
        check({tag, "_total"}, 32'(recv_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < recv_q.size(); i++)
            check({tag, "_word"}, 32'(recv_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int md;
        int lits [4];
        rst = 1'b1; enable = 1'b0; subc_tick = 1'b0; pat_ready = 1'b1;
        mode = '0; pat_in = '0; win_lo = '0; win_hi = '0;
        num_pat = '0; mask_chng_subc = '0; mask_chng_no = '0;
        cycle();
        cycle();
        check("rst_valid", 32'(pat_valid), 32'd0);
        check("rst_data", 32'(pat_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        cycle();

        // HOLD 0x155, three back-to-back words right after LOAD, then silence.
        ready_mode = 0;
        start_seq(0, 10'h155, 0, 9, 3, 1, 0);
        check("t1_load_valid", 32'(pat_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t1_valid", 32'(pat_valid), 32'd1);
            check("t1_data", 32'(pat_data), 32'h155);
        end
        cycle();
        check("t1_end_valid", 32'(pat_valid), 32'd0);
        repeat (5) cycle();
        check("t1_idle_valid", 32'(pat_valid), 32'd0);
        check("t1_idle_count", 32'(recv_q.size()), 32'd3);

        // ROTATE in window 0..3.
        run_scenario("t2", 1, 10'h001, 0, 3, 5, 1, 1);
        lits = '{1, 2, 4, 8};
        for (int k = 0; k < 4; k++)
            check("t2_literal", 32'(recv_q[k]), 32'(lits[k]));
        check("t2_literal_wrap", 32'(recv_q[4]), 32'h001);

        // Mask-change schedule: two subframes per change, two changes.
        run_scenario("t3", 1, 10'h001, 0, 9, 1, 2, 2);
        lits = '{1, 1, 2, 2};
        for (int k = 0; k < 4; k++)
            check("t3_literal", 32'(recv_q[k]), 32'(lits[k]));

        // Ready toggling during FILL.
        ready_mode = 1;
        run_scenario("t4", 1, 10'h0A5, 2, 6, 7, 1, 2);

        // Two ticks in one FILL: overrun sticky, one pending tick served.
        start_seq(0, 10'h2AA, 0, 9, 20, 1, 0);
        repeat (6) cycle();
        pulse_tick();
        cycle();
        cycle();
        pulse_tick();
        cycle();
        check("t5_overrun_set", 32'(overrun), 32'd1);
        wait_count("t5_count", 40);
        repeat (10) cycle();
        check("t5_no_extra", 32'(recv_q.size()), 32'd40);
        check("t5_last_word", 32'(recv_q[39]), 32'h2AA);
        check("t5_overrun_sticky", 32'(overrun), 32'd1);
        start_seq(0, 10'h2AA, 0, 9, 20, 1, 0);
        check("t5_overrun_clear", 32'(overrun), 32'd0);

        // Mode 2, window 0..3, zero seed.
        ready_mode = 0;
        start_seq(2, 10'h000, 0, 3, 16, 1, 0);
        wait_count("t6_count", 16);
`ifdef MASK_SEQ_LFSR_EN
        check("t6_first", 32'(recv_q[0]), 32'h001);
        check("t6_period", 32'(recv_q[15]), 32'(recv_q[0]));
        for (int k = 1; k < 15; k++)
            check("t6_no_early_repeat", 32'(recv_q[k] == recv_q[0]), 32'd0);
        for (int k = 0; k < 16; k++)
            check("t6_outside", 32'(recv_q[k] & 10'h3F0), 32'd0);
`else
        for (int k = 0; k < 16; k++)
            check("t6_hold", 32'(recv_q[k]), 32'h000);
`endif

        // Randomized configurations, including illegal windows and zero counts.
        for (int r = 0; r < 8; r++) begin
            md = int'($urandom_range(0, 3));
`ifdef MASK_SEQ_LFSR_EN
            if (md == 2) md = 1;
`endif
            ready_mode = int'($urandom_range(0, 2));
            run_scenario("rnd", md, N_CH'($urandom), int'($urandom_range(0, 11)),
                         int'($urandom_range(0, 11)), int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        // Reset in the middle of a FILL.
        ready_mode = 0;
        start_seq(0, 10'h3C3, 0, 9, 10, 1, 0);
        repeat (3) cycle();
        mon_en = 1'b0;
        rst    = 1'b1;
        enable = 1'b0;
        cycle();
        check("midrst_valid", 32'(pat_valid), 32'd0);
        check("midrst_data", 32'(pat_data), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (3) cycle();
        check("midrst_idle", 32'(pat_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
